ms_jk_bank: RTL
===============

MS_JK_BANK -- requirements
Module: ms_jk_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of flip-flop bits (legal range 1..32).
REQ-002 SHALL have parameter RESET_VAL, default 0 (WIDTH bits), value loaded into master and slave on reset.
REQ-003 SHALL have port clk  input  1  single clock; master captures on rising edge, slave captures on falling edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  update enable for the master stage.
REQ-006 SHALL have port load  input  1  parallel load request.
REQ-007 SHALL have port mode  input  2  00 JK, 01 T, 10 D, 11 COUNT.
REQ-008 SHALL have port d  input  WIDTH  parallel load data.
REQ-009 SHALL have port j  input  WIDTH  per-bit J (JK), T (T mode) or D (D mode).
REQ-010 SHALL have port k  input  WIDTH  per-bit K; used only in JK mode.
REQ-011 SHALL have port q  output  WIDTH  slave-stage state.
REQ-012 SHALL have port qn  output  WIDTH  bitwise complement of q.
REQ-013 SHALL have port master_q  output  WIDTH  master-stage state, for observation.
REQ-014 SHALL have port changed  output  1  registered flag: q changed at the last falling edge.
REQ-015 SHALL have port tc  output  1  terminal count: mode==11 and q all ones.

Function
REQ-016 SHALL update the master only on the rising clk edge, and the slave only on the falling clk edge (q <= master_q).
REQ-017 SHALL present a master update from rising edge N on q at the falling edge of the same cycle (half-cycle latency); q SHALL be stable for the whole high phase.
REQ-018 SHALL give load=1 priority over en and mode: master <= d at the rising edge.
REQ-019 SHALL hold the master when load=0 and en=0.
REQ-020 SHALL, in JK mode (load=0, en=1), apply per bit {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-021 SHALL, in T mode, toggle each bit whose j=1 and hold each bit whose j=0; k is ignored.
REQ-022 SHALL, in D mode, set master <= j; k is ignored.
REQ-023 SHALL, in COUNT mode, set master <= master + 1 modulo 2^WIDTH (all-ones wraps to 0); j and k are ignored.
REQ-024 SHALL compute all next-state functions from master_q, not from q.
REQ-025 SHALL register changed at each falling edge as (master_q != q), sampled before the slave update; changed SHALL therefore be high for exactly one clock period per change.
REQ-026 SHALL drive qn and tc combinationally from q and mode; tc SHALL drop in the same cycle that mode leaves 11.
REQ-027 SHALL respond to a mode change on the next rising edge only; no state is altered by the mode change itself.

Reset
REQ-028 SHALL, while reset_n=0, force master_q and q to RESET_VAL and changed to 0 immediately, independent of clk.
REQ-029 SHALL, when reset asserts mid-cycle (either clock phase), discard the pending master value; no stale value reaches q.
REQ-030 SHALL apply the first update at the first rising edge at which reset_n is already high; a falling edge after release with no intervening rising edge SHALL leave q = RESET_VAL and changed = 0.

Verification (WIDTH=4, RESET_VAL=0)
REQ-031 SHALL be covered by the following scenario: reset, then mode=00, en=1, j=1010, k=0101 -> q=1010 at the following falling edge; then j=k=1111 -> q=0101; then j=k=0000 -> q held at 0101 and changed=0.
REQ-032 SHALL be covered by the following scenario: mode=11, en=1 from q=0000 for 17 rising edges -> q steps 0001..1111, 0000, 0001; tc=1 only while q=1111; changed=1 in every cycle.
REQ-033 SHALL be covered by the following scenario: load=1, d=0110, en=0, mode=11 -> q=0110 after one cycle; then load=0, en=0 -> q held at 0110 for 3 cycles and changed=0.
REQ-034 SHALL be covered by the following scenario: mode=01, j=0011 from q=0110 -> q=0101, then q=0110; mode=10, j=1001 -> q=1001.
REQ-035 SHALL be covered by the following scenario: reset_n pulsed low during the clk-high phase after a rising edge that loaded 1111 -> q and master_q read 0000 immediately; q does not become 1111 at the falling edge; changed=0.
REQ-036 SHALL be covered by the following check over all scenarios: qn == ~q in every cycle, and q changes only at falling clk edges or on reset.

Source files
------------

// File: rtl/ms_jk_bank.sv
`default_nettype none
// ============================================================================
// Module   : ms_jk_bank
// Brief    : Bank of master-slave JK/T/D/counter flip-flops; master on rising
//            edge, slave on falling edge, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module ms_jk_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             load,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] master_q,
   output logic             changed,
   output logic             tc
);

   localparam logic [1:0]       c_mode_jk  = 2'b00;
   localparam logic [1:0]       c_mode_t   = 2'b01;
   localparam logic [1:0]       c_mode_d   = 2'b10;
   localparam logic [1:0]       c_mode_cnt = 2'b11;
   localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

   logic [WIDTH-1:0] r_master;
   logic [WIDTH-1:0] r_slave;
   logic             r_changed;
   logic [WIDTH-1:0] w_next;

   // Next state is always derived from the master, never from the slave.
   always_comb begin
      w_next = r_master;
      if (load) begin
         w_next = d;
      end else if (en) begin
         case (mode)
            c_mode_jk:  w_next = (j & ~r_master) | (~k & r_master);
            c_mode_t:   w_next = r_master ^ j;
            c_mode_d:   w_next = j;
            c_mode_cnt: w_next = r_master + c_one;
            default:    w_next = r_master;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_master <= RESET_VAL;
      end else begin
         r_master <= w_next;
      end
   end

   // Slave and change flag share the falling edge; changed compares before the copy.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_slave   <= RESET_VAL;
         r_changed <= 1'b0;
      end else begin
         r_slave   <= r_master;
         r_changed <= (r_master != r_slave);
      end
   end

   assign q        = r_slave;
   assign qn       = ~r_slave;
   assign master_q = r_master;
   assign changed  = r_changed;
   assign tc       = (mode == c_mode_cnt) && (&r_slave);

endmodule
`default_nettype wire
